// File: rtl/handshake_protocol_monitor.sv
// Passive N-channel ready/valid checker: flags valid drops, data changes and stall timeouts,
// counts transfers, latches the first error. Flags/counters appear one cycle after the edge; never stalls.
module handshake_protocol_monitor #(
  parameter int N       = 3,
  parameter int W       = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                                 CLK,
  input  logic                                 ASYNCRESETN,
  input  logic                                 clear,
  input  logic [N-1:0]                         valid,
  input  logic [N-1:0]                         ready,
  input  logic [N*W-1:0]                       data,
  output logic [N*CNT_W-1:0]                   xfer_count,
  output logic [N-1:0]                         err_valid_drop,
  output logic [N-1:0]                         err_data_change,
  output logic [N-1:0]                         err_timeout,
  output logic                                 any_err,
  output logic                                 first_err_valid,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] first_err_chan,
  output logic [1:0]                           first_err_code
);
  localparam int CHW = (N > 1) ? $clog2(N) : 1;
  localparam int SW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT);
  localparam logic [SW-1:0] STALL_HIT = SW'(TIMEOUT - 1);

  logic [N-1:0]            prev_valid_q, prev_ready_q;
  logic [N-1:0][W-1:0]     prev_data_q;
  logic [N-1:0][SW-1:0]    stall_q, stall_d;
  logic [N-1:0][CNT_W-1:0] xfer_q, xfer_d;
  logic [N-1:0]            vd_q, dc_q, to_q;
  logic [N-1:0]            vd_hit, dc_hit, to_hit;
  logic                    fe_valid_q, any_hit;
  logic [CHW-1:0]          fe_chan_q, fe_chan_d;
  logic [1:0]              fe_code_q, fe_code_d;
  logic [N-1:0]            pending, stalled, xfer;

  assign pending = prev_valid_q & ~prev_ready_q;
  assign stalled = valid & ~ready;
  assign xfer    = valid & ready;

  always_comb begin
    vd_hit    = '0;
    dc_hit    = '0;
    to_hit    = '0;
    stall_d   = stall_q;
    xfer_d    = xfer_q;
    any_hit   = 1'b0;
    fe_chan_d = '0;
    fe_code_d = '0;
    for (int i = 0; i < N; i++) begin
      vd_hit[i] = pending[i] & ~valid[i];
      dc_hit[i] = pending[i] & valid[i] & (data[i*W +: W] != prev_data_q[i]);
      to_hit[i] = (TIMEOUT != 0) && stalled[i] && (stall_q[i] == STALL_HIT);
      // Saturating at TIMEOUT keeps the compare above from matching twice in one stall.
      if (!stalled[i]) begin
        stall_d[i] = '0;
      end else if (stall_q[i] != STALL_MAX) begin
        stall_d[i] = stall_q[i] + SW'(1);
      end
      if (xfer[i] && (xfer_q[i] != {CNT_W{1'b1}})) begin
        xfer_d[i] = xfer_q[i] + CNT_W'(1);
      end
      // Ascending scan: lowest channel wins, then valid_drop > data_change > timeout.
      if (!any_hit && (vd_hit[i] || dc_hit[i] || to_hit[i])) begin
        any_hit   = 1'b1;
        fe_chan_d = CHW'(i);
        fe_code_d = vd_hit[i] ? 2'd1 : (dc_hit[i] ? 2'd2 : 2'd3);
      end
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      prev_valid_q <= '0;
      prev_ready_q <= '0;
      prev_data_q  <= '0;
      stall_q      <= '0;
      xfer_q       <= '0;
      vd_q         <= '0;
      dc_q         <= '0;
      to_q         <= '0;
      fe_valid_q   <= 1'b0;
      fe_chan_q    <= '0;
      fe_code_q    <= '0;
    end else begin
      // History keeps sampling through clear so a pending transfer is still checked.
      prev_valid_q <= valid;
      prev_ready_q <= ready;
      prev_data_q  <= data;
      if (clear) begin
        stall_q    <= '0;
        xfer_q     <= '0;
        vd_q       <= '0;
        dc_q       <= '0;
        to_q       <= '0;
        fe_valid_q <= 1'b0;
        fe_chan_q  <= '0;
        fe_code_q  <= '0;
      end else begin
        stall_q <= stall_d;
        xfer_q  <= xfer_d;
        vd_q    <= vd_q | vd_hit;
        dc_q    <= dc_q | dc_hit;
        to_q    <= to_q | to_hit;
        if (!fe_valid_q && any_hit) begin
          fe_valid_q <= 1'b1;
          fe_chan_q  <= fe_chan_d;
          fe_code_q  <= fe_code_d;
        end
      end
    end
  end

  assign xfer_count      = xfer_q;
  assign err_valid_drop  = vd_q;
  assign err_data_change = dc_q;
  assign err_timeout     = to_q;
  assign any_err         = |{vd_q, dc_q, to_q};
  assign first_err_valid = fe_valid_q;
  assign first_err_chan  = fe_chan_q;
  assign first_err_code  = fe_code_q;
endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Bench for handshake_protocol_monitor: directed scenarios plus randomized traffic
// scored against a run-length based reference model.
module tb_handshake_protocol_monitor;
  localparam int N = 3;
  localparam int W = 4;
  localparam int CNT_W = 8;
  localparam int TIMEOUT = 16;

  logic CLK = 1'b0;
  logic ASYNCRESETN = 1'b0;
  logic clear = 1'b0;
  logic [N-1:0] valid = '0;
  logic [N-1:0] ready = '0;
  logic [N-1:0][W-1:0] data = '0;
  logic [N-1:0][CNT_W-1:0] xfer_count;
  logic [N-1:0] err_valid_drop, err_data_change, err_timeout;
  logic any_err, first_err_valid;
  logic [1:0] first_err_chan, first_err_code;

  int checks = 0;
  int errors = 0;

  handshake_protocol_monitor #(.N(N), .W(W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .clear(clear),
    .valid(valid), .ready(ready), .data(data),
    .xfer_count(xfer_count), .err_valid_drop(err_valid_drop),
    .err_data_change(err_data_change), .err_timeout(err_timeout),
    .any_err(any_err), .first_err_valid(first_err_valid),
    .first_err_chan(first_err_chan), .first_err_code(first_err_code)
  );

  always #5 CLK = ~CLK;

  // Reference model: transfers as plain integers, stalls as unbounded run lengths.
  int m_cnt[N];
  int m_run[N];
  int m_pd[N];
  bit [N-1:0] m_pv, m_pr, m_vd, m_dc, m_to;
  bit m_fev;
  int m_fech, m_fecode;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0; m_run[i] = 0; m_pd[i] = 0;
    end
    m_pv = '0; m_pr = '0; m_vd = '0; m_dc = '0; m_to = '0;
    m_fev = 0; m_fech = 0; m_fecode = 0;
  endtask

  task automatic model_edge();
    bit [N-1:0] hvd, hdc, hto;
    int newrun[N];
    bit pend;
    for (int i = 0; i < N; i++) begin
      pend = m_pv[i] && !m_pr[i];
      hvd[i] = pend && !valid[i];
      hdc[i] = pend && valid[i] && (int'(data[i]) != m_pd[i]);
      newrun[i] = (valid[i] && !ready[i]) ? m_run[i] + 1 : 0;
      hto[i] = (TIMEOUT != 0) && (newrun[i] == TIMEOUT);
    end
    if (clear) begin
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_run[i] = 0; end
      m_vd = '0; m_dc = '0; m_to = '0; m_fev = 0; m_fech = 0; m_fecode = 0;
    end else begin
      m_vd |= hvd; m_dc |= hdc; m_to |= hto;
      for (int i = 0; i < N; i++) begin
        if (valid[i] && ready[i] && m_cnt[i] < 2**CNT_W - 1) m_cnt[i]++;
        m_run[i] = newrun[i];
      end
      for (int i = 0; i < N; i++) begin
        if (!m_fev && (hvd[i] || hdc[i] || hto[i])) begin
          m_fev = 1; m_fech = i;
          m_fecode = hvd[i] ? 1 : (hdc[i] ? 2 : 3);
        end
      end
    end
    for (int i = 0; i < N; i++) m_pd[i] = int'(data[i]);
    m_pv = valid; m_pr = ready;
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    ASYNCRESETN = 1'b0; clear = 1'b0; valid = '0; ready = '0; data = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    ASYNCRESETN = 1'b1;
  endtask

  task automatic test_reset();
    valid = '1; ready = '0; data = '1;
    ASYNCRESETN = 1'b0;
    model_reset();
    @(negedge CLK);
    checks++; if (xfer_count !== '0) begin errors++; $display("FAIL reset_count: got %h want 0", xfer_count); end
    checks++; if ({err_valid_drop, err_data_change, err_timeout} !== '0) begin errors++; $display("FAIL reset_flags: got %b want 0", {err_valid_drop, err_data_change, err_timeout}); end
    checks++; if (any_err !== 1'b0) begin errors++; $display("FAIL reset_any: got %b want 0", any_err); end
    checks++; if ({first_err_valid, first_err_chan, first_err_code} !== 5'b0) begin errors++; $display("FAIL reset_first: got %b want 0", {first_err_valid, first_err_chan, first_err_code}); end
  endtask

  task automatic test_basic();
    do_reset();
    valid[0] = 1'b1; data[0] = 4'hA; ready[0] = 1'b0;
    repeat (3) cyc();
    ready[0] = 1'b1; cyc();
    valid[0] = 1'b0; ready[0] = 1'b0; cyc();
    checks++; if ({err_valid_drop, err_data_change, err_timeout} !== '0) begin errors++; $display("FAIL basic_flags: got %b want 0", {err_valid_drop, err_data_change, err_timeout}); end
    checks++; if (xfer_count[0] !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", xfer_count[0]); end
    checks++; if (any_err !== 1'b0) begin errors++; $display("FAIL basic_any: got %b want 0", any_err); end
  endtask

  task automatic test_valid_drop();
    do_reset();
    valid[1] = 1'b1; ready[1] = 1'b0; data[1] = 4'h3; cyc();
    valid[1] = 1'b0; cyc();
    checks++; if (err_valid_drop !== 3'b010) begin errors++; $display("FAIL vdrop_flag: got %b want 010", err_valid_drop); end
    checks++; if ({err_data_change, err_timeout} !== '0) begin errors++; $display("FAIL vdrop_other: got %b want 0", {err_data_change, err_timeout}); end
    checks++; if ({first_err_valid, first_err_chan, first_err_code} !== {1'b1, 2'd1, 2'd1}) begin errors++; $display("FAIL vdrop_first: got %b want 10101", {first_err_valid, first_err_chan, first_err_code}); end
    checks++; if (any_err !== 1'b1) begin errors++; $display("FAIL vdrop_any: got %b want 1", any_err); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    valid = 3'b101; ready = '0; data[2] = 4'h5; data[0] = 4'h1; cyc();
    data[2] = 4'h6; valid[0] = 1'b0; cyc();
    checks++; if (err_valid_drop !== 3'b001) begin errors++; $display("FAIL simul_vd: got %b want 001", err_valid_drop); end
    checks++; if (err_data_change !== 3'b100) begin errors++; $display("FAIL simul_dc: got %b want 100", err_data_change); end
    checks++; if ({first_err_valid, first_err_chan, first_err_code} !== {1'b1, 2'd0, 2'd1}) begin errors++; $display("FAIL simul_first: got %b want 10001", {first_err_valid, first_err_chan, first_err_code}); end
  endtask

  task automatic test_timeout();
    do_reset();
    valid[0] = 1'b1; ready[0] = 1'b0; data[0] = 4'h7;
    repeat (15) cyc();
    checks++; if (err_timeout !== 3'b000) begin errors++; $display("FAIL tmo_early: got %b want 000", err_timeout); end
    cyc();
    checks++; if (err_timeout !== 3'b001) begin errors++; $display("FAIL tmo_edge16: got %b want 001", err_timeout); end
    checks++; if ({first_err_valid, first_err_chan, first_err_code} !== {1'b1, 2'd0, 2'd3}) begin errors++; $display("FAIL tmo_first: got %b want 10011", {first_err_valid, first_err_chan, first_err_code}); end
    repeat (24) cyc();
    checks++; if ({err_valid_drop, err_data_change, err_timeout} !== 9'b000_000_001) begin errors++; $display("FAIL tmo_held: got %b want 000000001", {err_valid_drop, err_data_change, err_timeout}); end
    clear = 1'b1; cyc(); clear = 1'b0;
    checks++; if ({xfer_count, err_valid_drop, err_data_change, err_timeout, any_err, first_err_valid, first_err_chan, first_err_code} !== '0) begin errors++; $display("FAIL tmo_clear: outputs not all zero, flags %b", {err_valid_drop, err_data_change, err_timeout}); end
    repeat (10) cyc();
    checks++; if (err_timeout !== 3'b000) begin errors++; $display("FAIL tmo_restart: got %b want 000", err_timeout); end
  endtask

  task automatic test_saturate();
    do_reset();
    valid[2] = 1'b1; ready[2] = 1'b1; data[2] = 4'h4;
    repeat (254) cyc();
    checks++; if (xfer_count[2] !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", xfer_count[2]); end
    repeat (46) cyc();
    checks++; if (xfer_count[2] !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", xfer_count[2]); end
    checks++; if (any_err !== 1'b0) begin errors++; $display("FAIL sat_any: got %b want 0", any_err); end
  endtask

  task automatic test_clear_discard();
    do_reset();
    valid[1] = 1'b1; ready[1] = 1'b0; data[1] = 4'h9;
    valid[0] = 1'b1; ready[0] = 1'b1; cyc();
    valid[1] = 1'b0; clear = 1'b1; cyc(); clear = 1'b0;
    checks++; if ({err_valid_drop, any_err, first_err_valid} !== 5'b0) begin errors++; $display("FAIL clr_discard: got %b want 0", {err_valid_drop, any_err, first_err_valid}); end
    checks++; if (xfer_count[0] !== 8'd0) begin errors++; $display("FAIL clr_xfer: got %0d want 0", xfer_count[0]); end
    valid = 3'b010; ready = '0; clear = 1'b1; cyc(); clear = 1'b0;
    valid[1] = 1'b0; cyc();
    checks++; if ({err_valid_drop, first_err_valid, first_err_chan, first_err_code} !== {3'b010, 1'b1, 2'd1, 2'd1}) begin errors++; $display("FAIL clr_pending: got %b want 010_1_01_01", {err_valid_drop, first_err_valid, first_err_chan, first_err_code}); end
  endtask

  task automatic test_async_reset();
    do_reset();
    valid = 3'b110; ready = '0; data[2] = 4'h2; data[1] = 4'h1;
    repeat (3) cyc();
    valid[1] = 1'b0; cyc();
    checks++; if (any_err !== 1'b1) begin errors++; $display("FAIL ar_pre: got %b want 1", any_err); end
    #2 ASYNCRESETN = 1'b0;
    model_reset();
    #1;
    checks++; if ({xfer_count, err_valid_drop, err_data_change, err_timeout, any_err, first_err_valid, first_err_chan, first_err_code} !== '0) begin errors++; $display("FAIL ar_immediate: flags %b any %b", {err_valid_drop, err_data_change, err_timeout}, any_err); end
    @(negedge CLK);
    ASYNCRESETN = 1'b1; valid[2] = 1'b0; cyc();
    checks++; if (any_err !== 1'b0) begin errors++; $display("FAIL ar_release: got %b want 0", any_err); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_pv[i] && !m_pr[i]) begin
          valid[i] = ($urandom_range(0, 19) != 0);
          if ($urandom_range(0, 9) == 0) data[i] = W'($urandom);
        end else begin
          valid[i] = $urandom_range(0, 1) == 1;
          data[i] = W'($urandom);
        end
        ready[i] = ($urandom_range(0, 2) == 0);
      end
      clear = ($urandom_range(0, 39) == 0);
      cyc();
      for (int i = 0; i < N; i++) begin
        checks++; if (xfer_count[i] !== CNT_W'(m_cnt[i])) begin errors++; $display("FAIL rnd_count[%0d] cyc %0d: got %0d want %0d", i, c, xfer_count[i], m_cnt[i]); end
      end
      checks++; if ({err_valid_drop, err_data_change, err_timeout} !== {m_vd, m_dc, m_to}) begin errors++; $display("FAIL rnd_flags cyc %0d: got %b want %b", c, {err_valid_drop, err_data_change, err_timeout}, {m_vd, m_dc, m_to}); end
      checks++; if (any_err !== |{m_vd, m_dc, m_to}) begin errors++; $display("FAIL rnd_any cyc %0d: got %b want %b", c, any_err, |{m_vd, m_dc, m_to}); end
      checks++; if ({first_err_valid, first_err_chan, first_err_code} !== {m_fev, 2'(m_fech), 2'(m_fecode)}) begin errors++; $display("FAIL rnd_first cyc %0d: got %b want %b", c, {first_err_valid, first_err_chan, first_err_code}, {m_fev, 2'(m_fech), 2'(m_fecode)}); end
    end
    clear = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_valid_drop();
    test_simultaneous();
    test_timeout();
    test_saturate();
    test_clear_discard();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
